// File: rtl/jk_cmd_seq.sv
// Command sequencer: queues (opcode, repeat) commands and drives J/K of a downstream
// JK flip-flop for len+1 cycles each, while tracking the flip-flop's predicted Q.
module jk_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic                          J,
    output logic                          K,
    output logic                          busy,
    output logic                          q_model,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    // Queue storage carries no reset; emptiness is defined by the level counter alone.
    logic [1:0]       op_mem_q  [FIFO_DEPTH];
    logic [LEN_W-1:0] len_mem_q [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic [0:0]       state_q,  state_d;
    logic [1:0]       op_q,     op_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic             qm_q,     qm_d;

    logic push;
    logic pop;
    logic fifo_nempty;
    logic issue_last;

    function automatic logic jk_next(input logic q, input logic [1:0] op);
        logic r;
        case (op)
            OP_HOLD:   r = q;
            OP_RESET:  r = 1'b0;
            OP_SET:    r = 1'b1;
            default:   r = ~q;
        endcase
        return r;
    endfunction

    assign cmd_ready   = (level_q < LVL_FULL);
    assign push        = cmd_valid & cmd_ready;
    assign fifo_nempty = (level_q != '0);
    assign issue_last  = (state_q == ST_ISSUE) && (cnt_q == '0);
    assign pop         = fifo_nempty && ((state_q == ST_IDLE) || issue_last);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // The final cycle of a command doubles as the load slot for the next one,
    // which is what keeps back-to-back commands free of idle gaps.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        qm_d    = qm_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_ISSUE;
                    op_d    = op_mem_q[rd_ptr_q];
                    cnt_d   = len_mem_q[rd_ptr_q];
                end
            end
            default: begin
                qm_d = jk_next(qm_q, op_q);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (pop) begin
                    op_d  = op_mem_q[rd_ptr_q];
                    cnt_d = len_mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= cmd_op;
            len_mem_q[wr_ptr_q] <= cmd_len;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            op_q     <= OP_HOLD;
            cnt_q    <= '0;
            qm_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            qm_q     <= qm_d;
        end
    end

    // J/K come only from registers so upstream cmd_* timing never reaches the flip-flop.
    assign busy       = (state_q == ST_ISSUE);
    assign J          = busy & op_q[1];
    assign K          = busy & op_q[0];
    assign q_model    = qm_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq: each accepted command expands into per-cycle
// expected {J,K,Q} entries that are consumed whenever the sequencer reports busy.
module tb_jk_cmd_seq;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             J, K, busy, q_model;
    logic [$clog2(DEPTH):0] fifo_level;

    typedef struct {
        logic [1:0] jk;
        logic       q;
    } exp_t;

    exp_t exp_q[$];
    int   runs[$];
    int   run_cnt = 0;
    logic q_track = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    jk_cmd_seq #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .J          (J),
        .K          (K),
        .busy       (busy),
        .q_model    (q_model),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic jk_ref(input logic q, input logic [1:0] op);
        case (op)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    task automatic sb_add(input logic [1:0] op, input logic [LEN_W-1:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back('{jk: op, q: q_track});
            q_track = jk_ref(q_track, op);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
        int g = 0;
        while (!cmd_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'd1, 32'd0);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        @(posedge clk);
        sb_add(op, len);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (busy || exp_q.size() != 0) chk(tag, 32'd1, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        exp_q.delete();
        runs.delete();
        q_track = 1'b0;
        #3;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (busy) begin
                run_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 32'(busy), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("jk_issue", 32'({J, K}), 32'(e.jk));
                    chk("q_issue", 32'(q_model), 32'(e.q));
                end
            end else begin
                if (run_cnt > 0) runs.push_back(run_cnt);
                run_cnt = 0;
                chk("jk_idle", 32'({J, K}), 32'd0);
                chk("q_idle", 32'(q_model), 32'(exp_q.size() != 0 ? exp_q[0].q : q_track));
            end
        end else begin
            run_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_jk", 32'({J, K}), 32'd0);
        chk("rst_q", 32'(q_model), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // SET len 2: first-issue latency, 3-cycle run, Q ends at 1
        runs.delete();
        push_cmd(2'b10, 4'd2);
        chk("lat_push_edge", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("lat_next_edge", 32'(busy), 32'd1);
        wait_idle("set_timeout");
        chk("set_run", runs.size() == 1 ? runs[0] : 32'hFFFF, 32'd3);
        chk("set_q", 32'(q_model), 32'd1);
        chk("set_jk_after", 32'({J, K}), 32'd0);

        // TOGGLE 0, TOGGLE 0, RESET 1 back-to-back from Q=0
        do_reset();
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b01, 4'd1);
        wait_idle("b2b_timeout");
        chk("b2b_runs", runs.size(), 32'd1);
        chk("b2b_run_len", runs.size() >= 1 ? runs[0] : 32'hFFFF, 32'd4);
        chk("b2b_q", 32'(q_model), 32'd0);

        // HOLD len 15: full 16-cycle run with no counter overflow
        runs.delete();
        push_cmd(2'b00, 4'd15);
        wait_idle("hold_timeout");
        chk("hold_run", runs.size() == 1 ? runs[0] : 32'hFFFF, 32'd16);

        // Full FIFO behind a long HOLD: a fifth command is refused
        runs.delete();
        push_cmd(2'b00, 4'd15);
        push_cmd(2'b10, 4'd0);
        push_cmd(2'b01, 4'd0);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b10, 4'd1);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = 4'd3;
        repeat (3) begin
            @(posedge clk); #1;
            chk("full_hold_level", 32'(fifo_level), 32'd4);
            chk("full_hold_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        begin
            int g = 0;
            while (fifo_level == 4 && g < 100) begin
                @(posedge clk); #1;
                g++;
            end
        end
        chk("after_pop_level", 32'(fifo_level), 32'd3);
        chk("after_pop_ready", 32'(cmd_ready), 32'd1);
        wait_idle("full_timeout");

        // Asynchronous reset in the middle of TOGGLE len 7 with two queued
        push_cmd(2'b11, 4'd7);
        push_cmd(2'b10, 4'd0);
        push_cmd(2'b01, 4'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #3;
        n_rst = 1'b0;
        exp_q.delete();
        q_track = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_jk", 32'({J, K}), 32'd0);
        chk("arst_q", 32'(q_model), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        runs.delete();
        n_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_runs", runs.size(), 32'd0);
        chk("no_stale_busy", 32'(busy), 32'd0);
        push_cmd(2'b10, 4'd0);
        chk("rel_lat_push_edge", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("rel_lat_next_edge", 32'(busy), 32'd1);
        wait_idle("rel_timeout");

        // Six ready-gated commands behind a HOLD: order survives pointer wrap
        push_cmd(2'b00, 4'd5);
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b11, 4'd2);
        push_cmd(2'b01, 4'd0);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b10, 4'd3);
        push_cmd(2'b11, 4'd1);
        wait_idle("wrap_timeout");
        chk("wrap_level", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
